// File: rtl/agnus_audio_dma.sv
// Agnus-side audio DMA responder: latches the four Paula audio requests at the line strobe and
// serves each in its fixed slot from the AUDxPT pointers. Build option AUDIO_DMA_ECS_ADDR_EN.
module agnus_audio_dma (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic        cck,
  input  logic [8:0]  hpos,
  input  logic        strhor,
  input  logic [3:0]  audio_dmareq,
  input  logic [3:0]  audio_dmas,
  input  logic [3:0]  aud_en,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic        reg_wr,
  output logic        dma,
  output logic [19:0] address_out,
  output logic [7:0]  reg_address_out
);

`ifdef AUDIO_DMA_ECS_ADDR_EN
  localparam int AW = 20;
`else
  localparam int AW = 18;
`endif

  localparam logic [AW-1:0] PTR_INC   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    LCH_BASE  = 8'h50;
  localparam logic [7:0]    LCL_BASE  = 8'h51;
  localparam logic [8:0]    SLOT_BASE = 9'h00D;

  logic [AW-1:0] lc_q  [4];
  logic [AW-1:0] lc_d  [4];
  logic [AW-1:0] ptr_q [4];
  logic [AW-1:0] ptr_d [4];
  logic [3:0]    pend_q;
  logic [3:0]    pend_d;
  logic [3:0]    rst_q;
  logic [3:0]    rst_d;
  logic [3:0]    slot_hit_s;
  logic [3:0]    serve_s;
  logic          unused_data_s;

  // LCL ignores bit 0 (word addresses only).
  assign unused_data_s = data_in[0];

  // Slot ownership and service decision per channel.
  always_comb begin
    slot_hit_s = 4'b0000;
    serve_s    = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      slot_hit_s[n] = (hpos == (SLOT_BASE + 9'(2 * n)));
      serve_s[n]    = slot_hit_s[n] & pend_q[n] & aud_en[n];
    end
  end

  // Bus outputs: the serving channel's pointer and AUDxDAT, else idle.
  always_comb begin
    case (serve_s)
      4'b0001: begin
        dma             = 1'b1;
        address_out     = 20'(ptr_q[0]);
        reg_address_out = 8'h55;
      end
      4'b0010: begin
        dma             = 1'b1;
        address_out     = 20'(ptr_q[1]);
        reg_address_out = 8'h5D;
      end
      4'b0100: begin
        dma             = 1'b1;
        address_out     = 20'(ptr_q[2]);
        reg_address_out = 8'h65;
      end
      4'b1000: begin
        dma             = 1'b1;
        address_out     = 20'(ptr_q[3]);
        reg_address_out = 8'h6D;
      end
      default: begin
        dma             = 1'b0;
        address_out     = 20'h00000;
        reg_address_out = 8'hFF;
      end
    endcase
  end

  // Next state: LC writes, slot-end pointer update, and the strobe latch (strobe wins for pend/rst).
  always_comb begin
    pend_d = pend_q;
    rst_d  = rst_q;
    for (int n = 0; n < 4; n++) begin
      lc_d[n]  = lc_q[n];
      ptr_d[n] = ptr_q[n];
    end
    if (clk7_en) begin
      for (int n = 0; n < 4; n++) begin
        if (reg_wr && (reg_address_in == (LCH_BASE + 8'(8 * n)))) begin
          lc_d[n][AW-1:15] = data_in[AW-16:0];
        end else if (reg_wr && (reg_address_in == (LCL_BASE + 8'(8 * n)))) begin
          lc_d[n][14:0] = data_in[15:1];
        end else begin
          lc_d[n] = lc_q[n];
        end
        // A restart reloads from the pre-write lc, so a coincident LC write only affects lc.
        if (cck && slot_hit_s[n]) begin
          pend_d[n] = 1'b0;
          if (serve_s[n]) begin
            ptr_d[n] = rst_q[n] ? lc_q[n] : (ptr_q[n] + PTR_INC);
          end else begin
            ptr_d[n] = ptr_q[n];
          end
        end else begin
          pend_d[n] = pend_q[n];
        end
      end
      if (strhor) begin
        pend_d = audio_dmareq;
        rst_d  = audio_dmas;
      end else begin
        rst_d = rst_q;
      end
    end else begin
      pend_d = pend_q;
      rst_d  = rst_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 4'b0000;
      rst_q  <= 4'b0000;
      for (int n = 0; n < 4; n++) begin
        lc_q[n]  <= {AW{1'b0}};
        ptr_q[n] <= {AW{1'b0}};
      end
    end else begin
      pend_q <= pend_d;
      rst_q  <= rst_d;
      for (int n = 0; n < 4; n++) begin
        lc_q[n]  <= lc_d[n];
        ptr_q[n] <= ptr_d[n];
      end
    end
  end

endmodule
